// File: rtl/imem_pkg.sv
// imem_pkg: types and constants shared by the instruction-memory boot loader.
//   state_t           loader FSM state encoding
//   HDR_BYTE_DEFAULT  default frame start marker
//   IMEM_WORDS        instruction-memory capacity in 32-bit words
//   max_int           helper for sizing the shared timeout counter
package imem_pkg;

    localparam int         IMEM_WORDS       = 256;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_HDR = 3'd0,
        LEN_HI   = 3'd1,
        LEN_LO   = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer: loadable down-counter shared by the boot window and
// the inter-byte timeout.
//   clk, reset  clock and synchronous active-high reset (reloads RST_VAL, armed)
//   load        arm the timer and load load_val
//   clr         disarm the timer; expire stays low until the next load
//   load_val    value loaded on load; expire fires load_val cycles later
//   expire      high while armed and the count has reached zero
// The FSM leaves its waiting state (and disarms the timer) on the same edge it
// sees expire, so expire is a single-cycle event in practice.
module byte_timeout_timer #(
    parameter int               WIDTH   = 27,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= RST_VAL;
            armed <= 1'b1;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (clr) begin
            armed <= 1'b0;
        end else if (armed && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = armed && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the CPU instruction memory.
// Holds the CPU stalled, waits for a framed image (HDR, LEN_HI, LEN_LO,
// N x 4 data bytes MSB first) on the UART byte stream and writes it word by
// word. Releases the CPU when done, or onto the resident image if no header
// arrives within BOOT_WAIT cycles. A short or oversized frame ends in ERR.
//   clk, reset    clock, synchronous active-high reset
//   rx_valid      one-cycle strobe, rx_data holds a received byte
//   rx_data       received byte
//   cpu_hold      1 = CPU stalled
//   we/waddr/wdata  instruction-memory write port (one we pulse per word)
//   load_done     sticky, CPU released
//   load_err      sticky, frame error, CPU stays held
//   words_loaded  words written since reset
//   dbg_state     current FSM state (state_t encoding)
// rx handshake: a byte is consumed on every cycle rx_valid is high in a state
// that accepts bytes; there is no backpressure.
module imem_loader
    import imem_pkg::*;
#(
    parameter int         ADDR_W       = $clog2(IMEM_WORDS),
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT,
    parameter int         BOOT_WAIT    = 50000000,
    parameter int         BYTE_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              cpu_hold,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    localparam int             TMR_W   = $clog2(max_int(BOOT_WAIT, BYTE_TIMEOUT) + 1);
    localparam int             CAP     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE    = 1;
    localparam logic [TMR_W-1:0] BYTE_RELOAD = TMR_W'(BYTE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] BOOT_RELOAD = TMR_W'(BOOT_WAIT - 1);

    state_t              state, state_d;
    logic [7:0]          len_hi, len_hi_d;
    logic [15:0]         len, len_d;
    logic [23:0]         asm_q, asm_d;
    logic [1:0]          bidx, bidx_d;
    logic                we_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic [31:0]         wdata_d;
    logic [ADDR_W:0]     words_d;
    logic                tmr_load, tmr_clr, expire;
    logic [15:0]         rx_len;
    logic                len_too_big, last_word;

    byte_timeout_timer #(
        .WIDTH   (TMR_W),
        .RST_VAL (BOOT_RELOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .clr      (tmr_clr),
        .load_val (BYTE_RELOAD),
        .expire   (expire)
    );

    assign rx_len      = {len_hi, rx_data};
    assign len_too_big = ({1'b0, rx_len} > 17'(CAP));
    assign last_word   = (16'(words_loaded) == (len - 16'd1));
    assign dbg_state   = state;

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_HDR;
            cpu_hold     <= 1'b1;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            len          <= '0;
            asm_q        <= '0;
            bidx         <= '0;
        end else begin
            state        <= state_d;
            // Release lags entry into DONE by one edge.
            cpu_hold     <= (state != DONE);
            we           <= we_d;
            waddr        <= waddr_d;
            wdata        <= wdata_d;
            load_done    <= (state_d == DONE);
            load_err     <= (state_d == ERR);
            words_loaded <= words_d;
            len_hi       <= len_hi_d;
            len          <= len_d;
            asm_q        <= asm_d;
            bidx         <= bidx_d;
        end
    end

    // Next state and timer control. A byte accepted in the expiry cycle
    // reloads the timer and wins over the timeout.
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        case (state)
            WAIT_HDR: begin
                if (rx_valid && (rx_data == HDR_BYTE)) begin
                    state_d  = LEN_HI;
                    tmr_load = 1'b1;
                end else if (expire) begin
                    state_d = DONE;
                    tmr_clr = 1'b1;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    state_d  = LEN_LO;
                    tmr_load = 1'b1;
                end else if (expire) begin
                    state_d = ERR;
                    tmr_clr = 1'b1;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    if (rx_len == 16'd0) begin
                        state_d = DONE;
                        tmr_clr = 1'b1;
                    end else if (len_too_big) begin
                        state_d = ERR;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d  = DATA;
                        tmr_load = 1'b1;
                    end
                end else if (expire) begin
                    state_d = ERR;
                    tmr_clr = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    tmr_load = 1'b1;
                    if ((bidx == 2'd3) && last_word) begin
                        state_d = DONE;
                    end
                end else if (expire) begin
                    state_d = ERR;
                    tmr_clr = 1'b1;
                end
            end
            default: tmr_clr = 1'b1;
        endcase
    end

    // Next values for the datapath and write port.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = waddr;
        wdata_d  = wdata;
        words_d  = words_loaded;
        len_hi_d = len_hi;
        len_d    = len;
        asm_d    = asm_q;
        bidx_d   = bidx;
        case (state)
            LEN_HI: if (rx_valid) len_hi_d = rx_data;
            LEN_LO: begin
                if (rx_valid) begin
                    len_d   = rx_len;
                    bidx_d  = 2'd0;
                    words_d = '0;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    asm_d  = {asm_q[15:0], rx_data};
                    bidx_d = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = words_loaded[ADDR_W-1:0];
                        wdata_d = {asm_q, rx_data};
                        words_d = words_loaded + ONE;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with BOOT_WAIT=100, BYTE_TIMEOUT=20, ADDR_W=8.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int SW = int'(WAIT_HDR);
    localparam int SH = int'(LEN_HI);
    localparam int SL = int'(LEN_LO);
    localparam int SD = int'(DATA);
    localparam int SN = int'(DONE);
    localparam int SE = int'(ERR);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_hold, we, load_done, load_err;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [8:0]  words_loaded;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int base;

    typedef struct {
        int          rst;
        int          v;
        int          d;
        int          we;
        int          wa;
        logic [31:0] wd;
        int          hold;
        int          done;
        int          err;
        int          words;
        int          st;
    } vec_t;

    vec_t vq[$];

    imem_loader #(
        .ADDR_W       (8),
        .HDR_BYTE     (8'hA5),
        .BOOT_WAIT    (100),
        .BYTE_TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .cpu_hold     (cpu_hold),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (we === 1'b1) we_cnt <= we_cnt + 1;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_we, input logic [31:0] e_wa,
                             input logic [31:0] e_wd, input logic [31:0] e_hold,
                             input logic [31:0] e_done, input logic [31:0] e_err,
                             input logic [31:0] e_words, input logic [31:0] e_st);
        check({tag, ".we"},    32'(we),           e_we);
        check({tag, ".waddr"}, 32'(waddr),        e_wa);
        check({tag, ".wdata"}, wdata,             e_wd);
        check({tag, ".hold"},  32'(cpu_hold),     e_hold);
        check({tag, ".done"},  32'(load_done),    e_done);
        check({tag, ".err"},   32'(load_err),     e_err);
        check({tag, ".words"}, 32'(words_loaded), e_words);
        check({tag, ".state"}, 32'(dbg_state),    e_st);
    endtask

    initial begin
        // Frame of two words, back-to-back bytes; then a byte in DONE is ignored.
        vq.push_back('{1, 1, 'hA5, 0, 0, 32'h0,        1, 0, 0, 0, SH});
        vq.push_back('{0, 1, 'h00, 0, 0, 32'h0,        1, 0, 0, 0, SL});
        vq.push_back('{0, 1, 'h02, 0, 0, 32'h0,        1, 0, 0, 0, SD});
        vq.push_back('{0, 1, 'h3C, 0, 0, 32'h0,        1, 0, 0, 0, SD});
        vq.push_back('{0, 1, 'h10, 0, 0, 32'h0,        1, 0, 0, 0, SD});
        vq.push_back('{0, 1, 'h40, 0, 0, 32'h0,        1, 0, 0, 0, SD});
        vq.push_back('{0, 1, 'h00, 1, 0, 32'h3C104000, 1, 0, 0, 1, SD});
        vq.push_back('{0, 1, 'h20, 0, 0, 32'h3C104000, 1, 0, 0, 1, SD});
        vq.push_back('{0, 1, 'h14, 0, 0, 32'h3C104000, 1, 0, 0, 1, SD});
        vq.push_back('{0, 1, 'hEC, 0, 0, 32'h3C104000, 1, 0, 0, 1, SD});
        vq.push_back('{0, 1, 'h77, 1, 1, 32'h2014EC77, 1, 1, 0, 2, SN});
        vq.push_back('{0, 0, 'h00, 0, 1, 32'h2014EC77, 0, 1, 0, 2, SN});
        vq.push_back('{0, 1, 'hA5, 0, 1, 32'h2014EC77, 0, 1, 0, 2, SN});
        // Garbage before the header, then N=0.
        vq.push_back('{1, 1, 'h00, 0, 0, 32'h0, 1, 0, 0, 0, SW});
        vq.push_back('{0, 1, 'hFF, 0, 0, 32'h0, 1, 0, 0, 0, SW});
        vq.push_back('{0, 1, 'hA5, 0, 0, 32'h0, 1, 0, 0, 0, SH});
        vq.push_back('{0, 1, 'h00, 0, 0, 32'h0, 1, 0, 0, 0, SL});
        vq.push_back('{0, 1, 'h00, 0, 0, 32'h0, 1, 1, 0, 0, SN});
        vq.push_back('{0, 0, 'h00, 0, 0, 32'h0, 0, 1, 0, 0, SN});
        // N=257 is an error; following bytes are ignored.
        vq.push_back('{1, 1, 'hA5, 0, 0, 32'h0, 1, 0, 0, 0, SH});
        vq.push_back('{0, 1, 'h01, 0, 0, 32'h0, 1, 0, 0, 0, SL});
        vq.push_back('{0, 1, 'h01, 0, 0, 32'h0, 1, 0, 1, 0, SE});
        vq.push_back('{0, 1, 'h3C, 0, 0, 32'h0, 1, 0, 1, 0, SE});
        vq.push_back('{0, 1, 'h10, 0, 0, 32'h0, 1, 0, 1, 0, SE});
        vq.push_back('{0, 1, 'h40, 0, 0, 32'h0, 1, 0, 1, 0, SE});
        vq.push_back('{0, 1, 'h00, 0, 0, 32'h0, 1, 0, 1, 0, SE});
        // N=256 exactly fills memory and is accepted.
        vq.push_back('{1, 1, 'hA5, 0, 0, 32'h0, 1, 0, 0, 0, SH});
        vq.push_back('{0, 1, 'h01, 0, 0, 32'h0, 1, 0, 0, 0, SL});
        vq.push_back('{0, 1, 'h00, 0, 0, 32'h0, 1, 0, 0, 0, SD});

        // Reset state
        do_reset();
        check_all("reset", 0, 0, 32'h0, 1, 0, 0, 0, SW);

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst != 0) do_reset();
            rx_valid = 1'(vq[i].v);
            rx_data  = 8'(vq[i].d);
            tick();
            rx_valid = 1'b0;
            check_all($sformatf("vec%0d", i), vq[i].we, vq[i].wa, vq[i].wd, vq[i].hold,
                      vq[i].done, vq[i].err, vq[i].words, vq[i].st);
        end

        // Boot window expiry with no rx activity
        do_reset();
        base = we_cnt;
        idle(99);
        check("boot.state99", 32'(dbg_state), SW);
        check("boot.done99",  32'(load_done), 0);
        idle(1);
        check_all("boot100", 0, 0, 32'h0, 1, 1, 0, 0, SN);
        idle(1);
        check("boot.hold101", 32'(cpu_hold), 0);
        check("boot.no_we", 32'(we_cnt - base), 0);

        // Inter-byte timeout in DATA
        do_reset();
        base = we_cnt;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h3C); send(8'h10);
        idle(19);
        check("tmo.state19", 32'(dbg_state), SD);
        check("tmo.err19",   32'(load_err), 0);
        idle(1);
        check_all("tmo20", 0, 0, 32'h0, 1, 0, 1, 0, SE);
        idle(5);
        check("tmo.err25",  32'(load_err), 1);
        check("tmo.hold25", 32'(cpu_hold), 1);
        check("tmo.no_we",  32'(we_cnt - base), 0);

        // Recovery after reset; a byte arriving on the expiry cycle is accepted.
        do_reset();
        check_all("recov.reset", 0, 0, 32'h0, 1, 0, 0, 0, SW);
        send(8'hA5); send(8'h00); send(8'h01); send(8'hDE);
        idle(19);
        send(8'hAD);
        check("recov.edge_state", 32'(dbg_state), SD);
        check("recov.edge_err",   32'(load_err), 0);
        send(8'hBE); send(8'hEF);
        check_all("recov.write", 1, 0, 32'hDEADBEEF, 1, 1, 0, 1, SN);
        idle(1);
        check_all("recov.release", 0, 0, 32'hDEADBEEF, 0, 1, 0, 1, SN);

        // Reset mid-DATA after the first word
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check_all("mid.write0", 1, 0, 32'h11223344, 1, 0, 0, 1, SD);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        tick();
        reset = 1'b0;
        rx_valid = 1'b0;
        check_all("mid.reset", 0, 0, 32'h0, 1, 0, 0, 0, SW);
        idle(1);
        check_all("mid.after", 0, 0, 32'h0, 1, 0, 0, 0, SW);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
